fetch_unit: RTL

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined core. Holds the PC, drives instruction-memory address, and registers the fetched word into IF/ID. Its opcode output feeds the control unit. It consumes the control unit's pc_op, b_jmp, halt and if_flush, plus the hazard stall. A small state machine handles sticky halt and stall hold.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 45 ++++
 rtl/fetch_unit_if_id_reg.sv | 33 +++
 rtl/fetch_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_e      : fetch FSM states (RUN, STALL, HALTED)
//   BUBBLE_INSTR : IF/ID filler word; opcode 1000 decodes to all-zero controls
//   OP_HALT      : halt opcode, which is why the bubble must not be 16'h0000
//   PC_INC       : sequential PC step in bytes
package fetch_pkg;
  typedef enum logic [1:0] {RUN, STALL, HALTED} state_e;

  localparam logic [15:0] BUBBLE_INSTR = 16'h8000;
  localparam logic [3:0]  OP_HALT      = 4'b0000;
  localparam int          PC_INC       = 2;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, control/hazard inputs from ID,
// and the IF/ID register outputs.
//   master : fetch_unit side (drives imem_addr, IF/ID outputs, halted)
//   slave  : environment side (memory, control unit, hazard unit)
// Macro FETCH_ALIGN_CHECK_EN adds misalign_error.
interface fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               pc_op;
  logic               b_jmp;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    jump_target;
  logic               halt;
  logic               if_flush;
  logic               stall;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc2;
  logic               if_id_valid;
  logic [3:0]         opcode;
  logic               halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               misalign_error;
`endif

  modport master (
`ifdef FETCH_ALIGN_CHECK_EN
    output misalign_error,
`endif
    output imem_addr, if_id_instr, if_id_pc2, if_id_valid, opcode, halted,
    input  imem_rdata, pc_op, b_jmp, branch_target, jump_target,
           halt, if_flush, stall
  );

  modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
    input  misalign_error,
`endif
    input  imem_addr, if_id_instr, if_id_pc2, if_id_valid, opcode, halted,
    output imem_rdata, pc_op, b_jmp, branch_target, jump_target,
           halt, if_flush, stall
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Priority: reset > bubble > load > hold.
//   clk, reset (sync, active-low)
//   load   : capture instr_d/pc2_d as a real instruction
//   bubble : capture BUBBLE_INSTR, valid=0
//   instr/pc2/valid : registered outputs
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [PC_W-1:0]    pc2_d,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc2,
  output logic               valid
);
  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      instr <= INSTR_W'(BUBBLE_INSTR);
      pc2   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc2   <= pc2_d;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch FSM and
// IF/ID register.
//   clk, reset (sync, active-low)
//   bus : fetch_unit_if.master (imem port, pc_op/b_jmp/targets, halt,
//         if_flush, stall in; IF/ID, opcode, halted out)
// Build option FETCH_ALIGN_CHECK_EN: an odd redirect target halts the stage
// and sets a sticky misalign_error; otherwise target bit0 is forced to 0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, tgt;
  logic            ld, bub;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            mis_q, mis_d;
`endif

  assign pc_inc = pc_q + PC_W'(PC_INC);   // wraps modulo 2^PC_W
  assign tgt    = bus.b_jmp ? bus.branch_target : bus.jump_target;

  // Priority: halt > pc_op > stall > normal/flush. HALTED ignores everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ld      = 1'b0;
    bub     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    if (state_q != HALTED) begin
      if (bus.halt) begin
        state_d = HALTED;
        bub     = 1'b1;
      end else if (bus.pc_op) begin
        state_d = RUN;
        bub     = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        if (tgt[0]) begin
          state_d = HALTED;
          mis_d   = 1'b1;
        end else begin
          pc_d = tgt;
        end
`else
        pc_d = {tgt[PC_W-1:1], 1'b0};
`endif
      end else if (bus.stall) begin
        state_d = STALL;
      end else begin
        // leaving STALL lands here, so that cycle is a normal fetch
        state_d = RUN;
        pc_d    = pc_inc;
        bub     = bus.if_flush;
        ld      = !bus.if_flush;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  if_id_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (ld),
    .bubble  (bub),
    .instr_d (bus.imem_rdata),
    .pc2_d   (pc_inc),
    .instr   (bus.if_id_instr),
    .pc2     (bus.if_id_pc2),
    .valid   (bus.if_id_valid)
  );

  assign bus.imem_addr = pc_q;
  assign bus.opcode    = bus.if_id_instr[INSTR_W-1 -: 4];
  assign bus.halted    = (state_q == HALTED);
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.misalign_error = mis_q;
`endif
endmodule
